// File: rtl/ring_inject_arbiter.sv
// ---------------------------------------------------------------------------
// ring_inject_arbiter
//
// Shares a single ring-router injection port among NUM_REQ local requesters.
// Arbitration is round-robin and packet-atomic: once a head flit is accepted
// the grant stays with that requester until its tail flit has been accepted,
// so flits of different packets never interleave on the ring. A credit
// counter mirrors the free slots of the router input buffer; no flit is
// injected without a credit.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_data[NUM_REQ]     flit payload per requester
//   req_dest[NUM_REQ]     destination per requester
//   req_is_tail           per requester: presented flit ends its packet
//   req_valid             per requester: a flit is presented
//   req_ready             per requester: flit accepted when valid & ready
//   data_out, dest_out,
//   is_tail_out, send_out registered flit towards the router (send_out is a
//                         one-cycle pulse per flit, one cycle after handshake)
//   credit_in             one credit returned by the router per pulse
//   credit_err            sticky, set when a credit returns while full
//   pkt_count[NUM_REQ]    (only with RING_INJ_PKT_COUNT_EN) per requester
//                         count of completed packets, wraps at 16 bits
//
// Optional feature macro: RING_INJ_PKT_COUNT_EN
// ---------------------------------------------------------------------------
module ring_inject_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DEST_WIDTH = 4,
   parameter int FLIT_WIDTH = 256,
   parameter int CREDITS    = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [FLIT_WIDTH-1:0] req_data    [NUM_REQ],
   input  logic [DEST_WIDTH-1:0] req_dest    [NUM_REQ],
   input  logic [NUM_REQ-1:0]    req_is_tail,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic [FLIT_WIDTH-1:0] data_out,
   output logic [DEST_WIDTH-1:0] dest_out,
   output logic                  is_tail_out,
   output logic                  send_out,
   input  logic                  credit_in,
`ifdef RING_INJ_PKT_COUNT_EN
   output logic [15:0]           pkt_count   [NUM_REQ],
`endif
   output logic                  credit_err
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(CREDITS + 1);
   localparam logic [CNT_W-1:0] CREDITS_FULL = CNT_W'(CREDITS);
   localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_REQ - 1);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   state_e                state_q, state_d;
   logic [IDX_W-1:0]      rr_q, rr_d;
   logic [IDX_W-1:0]      lock_q, lock_d;
   logic [CNT_W-1:0]      credit_q, credit_d;
   logic                  credit_err_q, credit_err_d;
   logic [FLIT_WIDTH-1:0] data_q, data_d;
   logic [DEST_WIDTH-1:0] dest_q, dest_d;
   logic                  tail_q, tail_d;
   logic                  send_q, send_d;

   logic [IDX_W-1:0]      sel;
   logic [IDX_W-1:0]      sel_next;
   logic [IDX_W-1:0]      cand;
   logic                  found;
   logic                  any_valid;
   logic                  has_credit;
   logic                  grant_ok;
   logic                  xfer;
   logic                  sel_tail;

   // ------------------------------------------------------------------------
   // Requester selection: the locked owner while a packet is open, otherwise
   // the first valid requester at or after the round-robin pointer.
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before any branch so that no path
      // leaves it unassigned; otherwise synthesis infers a latch.
      sel   = rr_q;
      cand  = '0;
      found = 1'b0;
      if (state_q == ST_LOCKED) begin
         sel = lock_q;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_q) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
               sel   = cand;
               found = 1'b1;
            end
         end
      end
   end

   assign sel_next   = (sel == LAST_IDX) ? '0 : sel + 1'b1;
   assign any_valid  = |req_valid;
   // Only credits held at the start of the cycle count; a credit returned in
   // this cycle becomes usable next cycle.
   assign has_credit = (credit_q != '0);
   assign grant_ok   = has_credit && ((state_q == ST_LOCKED) || any_valid);
   assign xfer       = grant_ok && req_valid[sel];
   assign sel_tail   = req_is_tail[sel];

   // Ready is offered to the selected requester even while a locked owner has
   // dropped valid; everyone else stays stalled so packets never interleave.
   always_comb begin
      req_ready = '0;
      if (grant_ok) begin
         req_ready[sel] = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Next state: credits, arbitration FSM and the output flit register.
   // ------------------------------------------------------------------------
   always_comb begin
      credit_d     = credit_q;
      credit_err_d = credit_err_q;
      unique case ({xfer, credit_in})
         2'b10:   credit_d = credit_q - CNT_W'(1);
         2'b01: begin
            // A credit arriving while the counter is full is a protocol
            // violation by the router; saturate and flag it.
            if (credit_q == CREDITS_FULL) begin
               credit_err_d = 1'b1;
            end else begin
               credit_d = credit_q + CNT_W'(1);
            end
         end
         default: credit_d = credit_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      lock_d  = lock_q;
      unique case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               if (sel_tail) begin
                  rr_d = sel_next;
               end else begin
                  state_d = ST_LOCKED;
                  lock_d  = sel;
               end
            end
         end
         ST_LOCKED: begin
            if (xfer && sel_tail) begin
               state_d = ST_IDLE;
               rr_d    = sel_next;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      data_d = data_q;
      dest_d = dest_q;
      tail_d = tail_q;
      send_d = xfer;
      if (xfer) begin
         data_d = req_data[sel];
         dest_d = req_dest[sel];
         tail_d = sel_tail;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the values from before the edge, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rr_q         <= '0;
         lock_q       <= '0;
         credit_q     <= CREDITS_FULL;
         credit_err_q <= 1'b0;
         send_q       <= 1'b0;
         tail_q       <= 1'b0;
         dest_q       <= '0;
         // NOTE: the wide payload register is reset too because the ring
         // observes data_out directly and must see zeros out of reset.
         data_q       <= '0;
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         lock_q       <= lock_d;
         credit_q     <= credit_d;
         credit_err_q <= credit_err_d;
         send_q       <= send_d;
         tail_q       <= tail_d;
         dest_q       <= dest_d;
         data_q       <= data_d;
      end
   end

   assign data_out    = data_q;
   assign dest_out    = dest_q;
   assign is_tail_out = tail_q;
   assign send_out    = send_q;
   assign credit_err  = credit_err_q;

`ifdef RING_INJ_PKT_COUNT_EN
   // Completed-packet counters, bumped on each accepted tail flit.
   logic [15:0] pkt_cnt_q [NUM_REQ];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            pkt_cnt_q[i] <= '0;
         end
      end else if (xfer && sel_tail) begin
         pkt_cnt_q[sel] <= pkt_cnt_q[sel] + 16'd1;
      end
   end

   assign pkt_count = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_ring_inject_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ring_inject_arbiter
//
// Self-checking bench for ring_inject_arbiter (NUM_REQ=4, CREDITS=2).
// A table of per-cycle vectors covers arbitration order, packet locking,
// credit stalls and credit return timing; hand-written sequences cover the
// credit overflow flag and reset mid-packet; a randomized phase compares the
// DUT against a behavioural model of the arbitration rules.
// Build with RING_INJ_PKT_COUNT_EN to include the packet counter check.
// ---------------------------------------------------------------------------
module tb_ring_inject_arbiter;

   localparam int NR = 4;
   localparam int DW = 4;
   localparam int FW = 256;
   localparam int CR = 2;

   typedef logic [FW-1:0] flit_t;

   logic          clk;
   logic          rst_n;
   logic [FW-1:0] req_data    [NR];
   logic [DW-1:0] req_dest    [NR];
   logic [NR-1:0] req_is_tail;
   logic [NR-1:0] req_valid;
   logic [NR-1:0] req_ready;
   logic [FW-1:0] data_out;
   logic [DW-1:0] dest_out;
   logic          is_tail_out;
   logic          send_out;
   logic          credit_in;
   logic          credit_err;
`ifdef RING_INJ_PKT_COUNT_EN
   logic [15:0]   pkt_count   [NR];
`endif

   ring_inject_arbiter #(
      .NUM_REQ   (NR),
      .DEST_WIDTH(DW),
      .FLIT_WIDTH(FW),
      .CREDITS   (CR)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_data   (req_data),
      .req_dest   (req_dest),
      .req_is_tail(req_is_tail),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .data_out   (data_out),
      .dest_out   (dest_out),
      .is_tail_out(is_tail_out),
      .send_out   (send_out),
      .credit_in  (credit_in),
`ifdef RING_INJ_PKT_COUNT_EN
      .pkt_count  (pkt_count),
`endif
      .credit_err (credit_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Distinct payload per (row, requester) so a flit from the wrong source or
   // the wrong cycle is always visible.
   function automatic flit_t mkdata(input int row, input int src);
      flit_t d;
      d            = '0;
      d[31:0]      = 32'(src) + 32'h100;
      d[127:96]    = 32'(row * 7 + src);
      d[255:224]   = 32'(row) ^ 32'hA5A5_0000;
      return d;
   endfunction

   task automatic drive(input logic [NR-1:0] v, input logic [NR-1:0] t, input logic c, input int row);
      req_valid   = v;
      req_is_tail = t;
      credit_in   = c;
      for (int i = 0; i < NR; i++) begin
         req_data[i] = mkdata(row, i);
         req_dest[i] = DW'(i);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive('0, '0, 1'b0, 0);
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // One record per clock: inputs applied, ready expected in that cycle, and
   // the registered flit expected right after the edge.
   typedef struct {
      logic [NR-1:0] valid;
      logic [NR-1:0] tail;
      logic          ci;
      logic [NR-1:0] exp_ready;
      logic          exp_send;
      logic          exp_tail;
      int            exp_src;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [NR-1:0] v, input logic [NR-1:0] t, input logic c,
                               input logic [NR-1:0] r, input logic s, input logic et, input int src);
      vec_t x;
      x.valid     = v;
      x.tail      = t;
      x.ci        = c;
      x.exp_ready = r;
      x.exp_send  = s;
      x.exp_tail  = et;
      x.exp_src   = src;
      return x;
   endfunction

   // Behavioural model state for the randomized phase.
   int            m_cred;
   bit            m_locked;
   int            m_lock;
   int            m_rr;
   int            held;
   int            pkt_len [NR];
   int            pkt_pos [NR];
   flit_t         cur_data[NR];
   logic [DW-1:0] cur_dest[NR];

   task automatic new_flit(input int i, input bit new_pkt);
      if (new_pkt) begin
         pkt_len[i] = $urandom_range(1, 4);
         pkt_pos[i] = 0;
      end
      for (int w = 0; w < FW / 32; w++) begin
         cur_data[i][w*32 +: 32] = $urandom();
      end
      cur_dest[i] = DW'($urandom_range(0, 15));
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [NR-1:0] exp_ready;
      logic [1:0]    gi;
      logic [1:0]    c;
      bit            gvalid;
      bit            did;
      flit_t         s_data;
      logic [DW-1:0] s_dest;
      logic          s_tail;

      // --------------------------------------------------------------------
      // Reset values
      // --------------------------------------------------------------------
      rst_n = 1'b0;
      drive('0, '0, 1'b0, 0);
      #2;
      check("rst send_out",    256'(send_out),    256'(0));
      check("rst is_tail_out", 256'(is_tail_out), 256'(0));
      check("rst credit_err",  256'(credit_err),  256'(0));
      check("rst req_ready",   256'(req_ready),   256'(0));
      check("rst data_out",    data_out,          256'(0));
      check("rst dest_out",    256'(dest_out),    256'(0));
      tick();
      tick();
      rst_n = 1'b1;

      // --------------------------------------------------------------------
      // Vector table (starts at rr=0, credits=2, IDLE)
      // --------------------------------------------------------------------
      // req0 and req2 two-flit packets contend; req0 first, no interleave
      vecs.push_back(mk(4'b0101, 4'b0000, 0, 4'b0001, 1, 0, 0));
      vecs.push_back(mk(4'b0101, 4'b0001, 0, 4'b0001, 1, 1, 0));
      vecs.push_back(mk(4'b0100, 4'b0000, 1, 4'b0000, 0, 0, 0));
      vecs.push_back(mk(4'b0100, 4'b0000, 1, 4'b0100, 1, 0, 2));
      vecs.push_back(mk(4'b0100, 4'b0100, 0, 4'b0100, 1, 1, 2));
      vecs.push_back(mk(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0));
      vecs.push_back(mk(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0));
      // next contention starts from requester 3, then wraps to 0
      vecs.push_back(mk(4'b1011, 4'b1011, 0, 4'b1000, 1, 1, 3));
      vecs.push_back(mk(4'b0011, 4'b0011, 0, 4'b0001, 1, 1, 0));
      // credits exhausted: stall until a credit returns, then one flit
      vecs.push_back(mk(4'b0010, 4'b0010, 0, 4'b0000, 0, 0, 0));
      vecs.push_back(mk(4'b0010, 4'b0010, 0, 4'b0000, 0, 0, 0));
      vecs.push_back(mk(4'b0010, 4'b0010, 1, 4'b0000, 0, 0, 0));
      vecs.push_back(mk(4'b0010, 4'b0010, 0, 4'b0010, 1, 1, 1));
      vecs.push_back(mk(4'b0010, 4'b0010, 0, 4'b0000, 0, 0, 0));
      vecs.push_back(mk(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0));
      vecs.push_back(mk(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0));
      // req1 drops valid mid-packet for 3 cycles; req3 must stay stalled
      vecs.push_back(mk(4'b0010, 4'b0000, 0, 4'b0010, 1, 0, 1));
      vecs.push_back(mk(4'b1000, 4'b1000, 1, 4'b0010, 0, 0, 0));
      vecs.push_back(mk(4'b1000, 4'b1000, 0, 4'b0010, 0, 0, 0));
      vecs.push_back(mk(4'b1000, 4'b1000, 0, 4'b0010, 0, 0, 0));
      vecs.push_back(mk(4'b1010, 4'b1010, 0, 4'b0010, 1, 1, 1));
      vecs.push_back(mk(4'b1000, 4'b1000, 1, 4'b1000, 1, 1, 3));
      vecs.push_back(mk(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0));
      // req0 three-flit packet, credit returned 2 cycles after each send
      vecs.push_back(mk(4'b0001, 4'b0000, 0, 4'b0001, 1, 0, 0));
      vecs.push_back(mk(4'b0001, 4'b0000, 0, 4'b0001, 1, 0, 0));
      vecs.push_back(mk(4'b0001, 4'b0001, 0, 4'b0000, 0, 0, 0));
      vecs.push_back(mk(4'b0001, 4'b0001, 1, 4'b0000, 0, 0, 0));
      vecs.push_back(mk(4'b0001, 4'b0001, 1, 4'b0001, 1, 1, 0));
      vecs.push_back(mk(4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0));
      vecs.push_back(mk(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0));

      for (int r = 0; r < vecs.size(); r++) begin
         drive(vecs[r].valid, vecs[r].tail, vecs[r].ci, r);
         #1;
         check($sformatf("tbl%0d req_ready", r), 256'(req_ready), 256'(vecs[r].exp_ready));
         @(posedge clk);
         #1;
         check($sformatf("tbl%0d send_out", r), 256'(send_out), 256'(vecs[r].exp_send));
         if (vecs[r].exp_send) begin
            check($sformatf("tbl%0d is_tail_out", r), 256'(is_tail_out), 256'(vecs[r].exp_tail));
            check($sformatf("tbl%0d data_out", r), data_out, mkdata(r, vecs[r].exp_src));
            check($sformatf("tbl%0d dest_out", r), 256'(dest_out), 256'(DW'(vecs[r].exp_src)));
         end
      end
      check("tbl credit_err", 256'(credit_err), 256'(0));

      // --------------------------------------------------------------------
      // Credit overflow: sticky flag, counter saturates at CREDITS
      // (state here: IDLE, rr=1, credits=2)
      // --------------------------------------------------------------------
      drive(4'b0000, 4'b0000, 1'b1, 100);
      tick();
      check("ovf credit_err set", 256'(credit_err), 256'(1));
      drive(4'b0000, 4'b0000, 1'b0, 101);
      tick();
      check("ovf credit_err sticky", 256'(credit_err), 256'(1));
      drive(4'b0001, 4'b0000, 1'b0, 102);
      #1;
      check("ovf ready flit1", 256'(req_ready), 256'(4'b0001));
      tick();
      drive(4'b0001, 4'b0000, 1'b0, 103);
      #1;
      check("ovf ready flit2", 256'(req_ready), 256'(4'b0001));
      tick();
      check("ovf send flit2", 256'(send_out), 256'(1));
      check("ovf data flit2", data_out, mkdata(103, 0));
      drive(4'b0001, 4'b0000, 1'b0, 104);
      #1;
      check("ovf count capped", 256'(req_ready), 256'(4'b0000));
      check("ovf credit_err still set", 256'(credit_err), 256'(1));

      // --------------------------------------------------------------------
      // Reset mid-packet (locked on req0, credits 0, send_out high)
      // --------------------------------------------------------------------
      req_valid = '0;
      rst_n     = 1'b0;
      #1;
      check("midrst send_out",    256'(send_out),    256'(0));
      check("midrst data_out",    data_out,          256'(0));
      check("midrst dest_out",    256'(dest_out),    256'(0));
      check("midrst is_tail_out", 256'(is_tail_out), 256'(0));
      check("midrst credit_err",  256'(credit_err),  256'(0));
      check("midrst req_ready",   256'(req_ready),   256'(0));
      tick();
      rst_n = 1'b1;
      // IDLE again (req1 granted, not the old lock owner) with two credits
      drive(4'b0010, 4'b0000, 1'b0, 105);
      #1;
      check("postrst ready 1", 256'(req_ready), 256'(4'b0010));
      tick();
      drive(4'b0010, 4'b0000, 1'b0, 106);
      #1;
      check("postrst ready 2", 256'(req_ready), 256'(4'b0010));
      tick();
      drive(4'b0010, 4'b0000, 1'b0, 107);
      #1;
      check("postrst credits=2", 256'(req_ready), 256'(4'b0000));

      // --------------------------------------------------------------------
      // Randomized traffic against the behavioural model
      // --------------------------------------------------------------------
      do_reset();
      m_cred   = CR;
      m_locked = 1'b0;
      m_lock   = 0;
      m_rr     = 0;
      held     = 0;
      for (int i = 0; i < NR; i++) begin
         new_flit(i, 1'b1);
      end

      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < NR; i++) begin
            req_valid[i]   = ($urandom_range(0, 99) < 60);
            req_is_tail[i] = (pkt_pos[i] == pkt_len[i] - 1);
            req_data[i]    = cur_data[i];
            req_dest[i]    = cur_dest[i];
         end
         credit_in = (held > 0) && ($urandom_range(0, 99) < 45);

         // Grant rule: no credit -> nobody; open packet -> its owner;
         // otherwise first valid requester from the pointer, wrapping.
         gvalid = 1'b0;
         gi     = '0;
         if (m_cred > 0) begin
            if (m_locked) begin
               gvalid = 1'b1;
               gi     = 2'(m_lock);
            end else begin
               for (int k = 0; k < NR; k++) begin
                  c = 2'((m_rr + k) % NR);
                  if (!gvalid && req_valid[c]) begin
                     gvalid = 1'b1;
                     gi     = c;
                  end
               end
            end
         end
         exp_ready = '0;
         if (gvalid) exp_ready[gi] = 1'b1;
         did    = gvalid && req_valid[gi];
         s_data = cur_data[gi];
         s_dest = cur_dest[gi];
         s_tail = req_is_tail[gi];

         #1;
         check($sformatf("rnd%0d req_ready", cyc), 256'(req_ready), 256'(exp_ready));
         tick();
         check($sformatf("rnd%0d send_out", cyc), 256'(send_out), 256'(did));
         if (did) begin
            check($sformatf("rnd%0d data_out", cyc), data_out, s_data);
            check($sformatf("rnd%0d dest_out", cyc), 256'(dest_out), 256'(s_dest));
            check($sformatf("rnd%0d is_tail_out", cyc), 256'(is_tail_out), 256'(s_tail));
         end

         if (did) begin
            m_cred--;
            held++;
            if (s_tail) begin
               m_locked = 1'b0;
               m_rr     = (int'(gi) + 1) % NR;
               new_flit(int'(gi), 1'b1);
            end else begin
               m_locked = 1'b1;
               m_lock   = int'(gi);
               pkt_pos[gi]++;
               new_flit(int'(gi), 1'b0);
            end
         end
         if (credit_in) begin
            m_cred++;
            held--;
         end
      end
      check("rnd credit_err clear", 256'(credit_err), 256'(0));

`ifdef RING_INJ_PKT_COUNT_EN
      // --------------------------------------------------------------------
      // Packet counters: req2 sends five single-flit packets
      // --------------------------------------------------------------------
      do_reset();
      for (int p = 0; p < 5; p++) begin
         drive(4'b0100, 4'b0100, 1'b0, 200 + p);
         tick();
         drive(4'b0000, 4'b0000, 1'b1, 300 + p);
         tick();
      end
      drive('0, '0, 1'b0, 0);
      for (int i = 0; i < NR; i++) begin
         check($sformatf("pkt_count[%0d]", i), 256'(pkt_count[i]), 256'((i == 2) ? 5 : 0));
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
